tt_bist_harness: RTL and testbench

- Parametrised on-chip built-in self-test harness for a TinyTapeout user design.
- An LFSR drives pseudo-random vectors onto the DUT's ui_in/uio_in.
- A MISR compresses the DUT's uo_out (and optionally uio_out) into a signature. The signature is compared with a golden value.
- Sits beside the user project, sharing its clk/rst_n/ena. Lets silicon be checked without a cocotb bench.

---
 rtl/tt_bist_harness_if.sv | 28 ++
 rtl/tt_bist_harness.sv | 129 ++++++++++++
 tb/tb_tt_bist_harness.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_bist_harness_if.sv
// Bus bundle for tt_bist_harness: run control, DUT stimulus/response and result status.
// The slave modport is the harness; the master modport is whoever requests runs and drives responses.
interface tt_bist_harness_if #(
  parameter int unsigned W = 8
) ();
  logic         start;
  logic [W-1:0] golden;
  logic [W-1:0] resp_uo;
  logic [W-1:0] resp_uio;
  logic [W-1:0] resp_uio_oe;
  logic [W-1:0] stim_ui;
  logic [W-1:0] stim_uio;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W-1:0] signature;
  logic [15:0]  vec_cnt;

  modport master (
    output start, golden, resp_uo, resp_uio, resp_uio_oe,
    input  stim_ui, stim_uio, busy, done, pass, signature, vec_cnt
  );

  modport slave (
    input  start, golden, resp_uo, resp_uio, resp_uio_oe,
    output stim_ui, stim_uio, busy, done, pass, signature, vec_cnt
  );
endinterface

// File: rtl/tt_bist_harness.sv
// LFSR-stimulus / MISR-signature self-test harness for a TinyTapeout user design.
// Define TT_BIST_UIO_EN to fold driven uio_out pins into the signature alongside uo_out.
module tt_bist_harness #(
  parameter int unsigned   W           = 8,
  parameter int unsigned   NUM_VECTORS = 16,
  parameter int unsigned   LATENCY     = 1,
  parameter logic [W-1:0] SEED        = 8'h01,
  parameter logic [W-1:0] TAPS        = 8'hB8
) (
  input logic              clk,
  input logic              rst_n,
  input logic              ena,
  tt_bist_harness_if.slave bus
);

  if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
    $error("tt_bist_harness: NUM_VECTORS must be in 1..65535");
  end
  if (LATENCY > 15) begin : g_bad_latency
    $error("tt_bist_harness: LATENCY must be in 0..15");
  end

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [W-1:0] SeedEff = (SEED == '0) ? W'(1) : SEED;
  localparam logic [3:0]   LatEnd  = LATENCY[3:0];
  localparam logic [15:0]  VecEnd  = NUM_VECTORS[15:0];

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] lfsr_q, lfsr_d;
  logic [W-1:0] misr_q, misr_d;
  logic [15:0]  vec_cnt_q, vec_cnt_d;
  logic [3:0]   lat_cnt_q, lat_cnt_d;
  logic [W-1:0] stim_ui_q, stim_ui_d;
  logic [W-1:0] stim_uio_q, stim_uio_d;
  logic         pass_q, pass_d;
  logic [W-1:0] misr_in;

  function automatic logic [W-1:0] shift_fb(input logic [W-1:0] v);
    return {v[W-2:0], ^(v & TAPS)};
  endfunction

`ifdef TT_BIST_UIO_EN
  // Pins the DUT leaves as inputs carry our own stimulus, so they are masked out.
  assign misr_in = bus.resp_uo ^ (bus.resp_uio & bus.resp_uio_oe);
`else
  logic unused_uio;
  assign unused_uio = ^{bus.resp_uio, bus.resp_uio_oe};
  assign misr_in    = bus.resp_uo;
`endif

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    misr_d     = misr_q;
    vec_cnt_d  = vec_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    stim_ui_d  = stim_ui_q;
    stim_uio_d = stim_uio_q;
    pass_d     = pass_q;
    if (ena) begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_d    = StRun;
            lfsr_d     = SeedEff;
            misr_d     = '0;
            vec_cnt_d  = '0;
            lat_cnt_d  = '0;
            stim_ui_d  = SeedEff;
            stim_uio_d = ~SeedEff;
            pass_d     = 1'b0;
          end
        end
        StRun: begin
          lfsr_d     = shift_fb(lfsr_q);
          stim_ui_d  = lfsr_d;
          stim_uio_d = ~lfsr_d;
          if (lat_cnt_q == LatEnd) begin
            misr_d    = shift_fb(misr_q) ^ misr_in;
            vec_cnt_d = (vec_cnt_q == 16'hFFFF) ? vec_cnt_q : vec_cnt_q + 16'd1;
            if (vec_cnt_d == VecEnd) begin
              state_d    = StDone;
              stim_ui_d  = '0;
              stim_uio_d = '0;
              // golden is only looked at here; later changes cannot disturb pass.
              pass_d     = (misr_d == bus.golden);
            end
          end else begin
            lat_cnt_d = lat_cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= SeedEff;
      misr_q     <= '0;
      vec_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      stim_ui_q  <= '0;
      stim_uio_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      misr_q     <= misr_d;
      vec_cnt_q  <= vec_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      stim_ui_q  <= stim_ui_d;
      stim_uio_q <= stim_uio_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.stim_ui   = stim_ui_q;
  assign bus.stim_uio  = stim_uio_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;
  assign bus.vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_tt_bist_harness.sv
// Self-checking bench for tt_bist_harness: directed scenarios on several parameterisations plus
// randomized runs scored against a signature model computed from the LFSR/MISR rules.
module tb_tt_bist_harness;
  localparam logic [7:0] Taps = 8'hB8;
  localparam int Nv3  = 16;
  localparam int Lat3 = 1;

  logic clk;
  logic rst_n;
  logic ena;
  int   n_pass;
  int   n_total;

  tt_bist_harness_if #(.W(8)) bif0 ();
  tt_bist_harness_if #(.W(8)) bif1 ();
  tt_bist_harness_if #(.W(8)) bif2 ();
  tt_bist_harness_if #(.W(8)) bif3 ();

  tt_bist_harness #(.W(8), .NUM_VECTORS(2), .LATENCY(0), .SEED(8'h01), .TAPS(Taps)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bif0)
  );
  tt_bist_harness #(.W(8), .NUM_VECTORS(1), .LATENCY(3), .SEED(8'h01), .TAPS(Taps)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bif1)
  );
  tt_bist_harness #(.W(8), .NUM_VECTORS(12), .LATENCY(0), .SEED(8'h01), .TAPS(Taps)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bif2)
  );
  tt_bist_harness #(.W(8), .NUM_VECTORS(Nv3), .LATENCY(Lat3), .SEED(8'h01), .TAPS(Taps)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bif3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Spec rule: shift left, feed back the parity of the tapped bits.
  function automatic logic [7:0] nx(input logic [7:0] v);
    int p;
    p = 0;
    for (int b = 0; b < 8; b++) if (Taps[b] && v[b]) p = p + 1;
    return 8'((int'(v) * 2 + (p % 2)) % 256);
  endfunction

  function automatic logic [7:0] mix(input logic [7:0] uo, input logic [7:0] uio,
                                     input logic [7:0] oe);
`ifdef TT_BIST_UIO_EN
    return uo ^ (uio & oe);
`else
    return uo;
`endif
  endfunction

  task automatic set_rand3();
    bif3.resp_uo     = 8'($urandom_range(0, 255));
    bif3.resp_uio    = 8'($urandom_range(0, 255));
    bif3.resp_uio_oe = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_run(input int freeze_at, input int mid_start_at, input bit good);
    logic [7:0] uo  [0:31];
    logic [7:0] uio [0:31];
    logic [7:0] oe  [0:31];
    logic [7:0] sig;
    logic [7:0] lf;
    logic [7:0] snap_stim;
    logic [7:0] snap_sig;
    logic [15:0] snap_cnt;
    int k;
    int busy_cycles;
    for (int i = 0; i < Nv3 + Lat3; i++) begin
      uo[i]  = 8'($urandom_range(0, 255));
      uio[i] = 8'($urandom_range(0, 255));
      oe[i]  = 8'($urandom_range(0, 255));
    end
    sig = 8'h00;
    for (int i = Lat3; i < Nv3 + Lat3; i++) sig = nx(sig) ^ mix(uo[i], uio[i], oe[i]);
    bif3.golden = good ? sig : sig ^ 8'h80;
    bif3.start = 1'b1;
    tick();
    bif3.start = 1'b0;
    chk("rr_sig_cleared", {24'd0, bif3.signature}, 32'h0);
    chk("rr_cnt_cleared", {16'd0, bif3.vec_cnt}, 32'h0);
    chk("rr_done_low", {31'd0, bif3.done}, 32'h0);
    lf = 8'h01;
    k = 0;
    busy_cycles = 0;
    while (k < Nv3 + Lat3 && busy_cycles < 100) begin
      if (k == freeze_at) begin
        snap_stim = bif3.stim_ui;
        snap_sig  = bif3.signature;
        snap_cnt  = bif3.vec_cnt;
        ena = 1'b0;
        bif3.start = 1'b1;
        repeat (5) begin
          set_rand3();
          tick();
        end
        chk("frz_stim", {24'd0, bif3.stim_ui}, {24'd0, snap_stim});
        chk("frz_sig", {24'd0, bif3.signature}, {24'd0, snap_sig});
        chk("frz_cnt", {16'd0, bif3.vec_cnt}, {16'd0, snap_cnt});
        chk("frz_busy", {31'd0, bif3.busy}, 32'h1);
        ena = 1'b1;
      end
      bif3.resp_uo     = uo[k];
      bif3.resp_uio    = uio[k];
      bif3.resp_uio_oe = oe[k];
      bif3.start       = (k == mid_start_at);
      chk("rr_stim_ui", {24'd0, bif3.stim_ui}, {24'd0, lf});
      chk("rr_busy", {31'd0, bif3.busy}, 32'h1);
      tick();
      lf = nx(lf);
      k++;
      busy_cycles++;
    end
    bif3.start = 1'b0;
    chk("rr_done", {31'd0, bif3.done}, 32'h1);
    chk("rr_busy_end", {31'd0, bif3.busy}, 32'h0);
    chk("rr_sig", {24'd0, bif3.signature}, {24'd0, sig});
    chk("rr_cnt", {16'd0, bif3.vec_cnt}, Nv3);
    chk("rr_pass", {31'd0, bif3.pass}, {31'd0, good});
    chk("rr_stim_idle", {24'd0, bif3.stim_ui}, 32'h0);
  endtask

  initial begin
    logic [7:0] lf;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    bif0.start = 0; bif0.golden = 0; bif0.resp_uo = 0; bif0.resp_uio = 0; bif0.resp_uio_oe = 0;
    bif1.start = 0; bif1.golden = 0; bif1.resp_uo = 0; bif1.resp_uio = 0; bif1.resp_uio_oe = 0;
    bif2.start = 0; bif2.golden = 0; bif2.resp_uo = 0; bif2.resp_uio = 0; bif2.resp_uio_oe = 0;
    bif3.start = 0; bif3.golden = 0; bif3.resp_uo = 0; bif3.resp_uio = 0; bif3.resp_uio_oe = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-run must abort straight to reset values.
    bif3.start = 1'b1;
    tick();
    bif3.start = 1'b0;
    repeat (6) begin
      set_rand3();
      tick();
    end
    chk("pre_rst_busy", {31'd0, bif3.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bif3.busy}, 32'h0);
    chk("rst_done", {31'd0, bif3.done}, 32'h0);
    chk("rst_pass", {31'd0, bif3.pass}, 32'h0);
    chk("rst_stim_ui", {24'd0, bif3.stim_ui}, 32'h0);
    chk("rst_stim_uio", {24'd0, bif3.stim_uio}, 32'h0);
    chk("rst_sig", {24'd0, bif3.signature}, 32'h0);
    chk("rst_cnt", {16'd0, bif3.vec_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, bif3.busy}, 32'h0);

    // LFSR sequence from SEED=01.
    bif2.start = 1'b1;
    tick();
    bif2.start = 1'b0;
    lf = 8'h01;
    for (int i = 0; i < 5; i++) begin
      chk("lfsr_ui", {24'd0, bif2.stim_ui}, {24'd0, lf});
      chk("lfsr_uio", {24'd0, bif2.stim_uio}, {24'd0, ~lf});
      lf = nx(lf);
      tick();
    end
    for (int i = 0; i < 50 && !bif2.done; i++) tick();
    chk("lfsr_done", {31'd0, bif2.done}, 32'h1);

    // Constant response 5A, two vectors.
    bif0.resp_uo = 8'h5A;
    bif0.golden  = 8'hEE;
    bif0.start   = 1'b1;
    tick();
    bif0.start = 1'b0;
    chk("c_busy0", {31'd0, bif0.busy}, 32'h1);
    chk("c_sig0", {24'd0, bif0.signature}, 32'h0);
    tick();
    chk("c_sig1", {24'd0, bif0.signature}, 32'h5A);
    chk("c_busy1", {31'd0, bif0.busy}, 32'h1);
    tick();
    chk("c_done", {31'd0, bif0.done}, 32'h1);
    chk("c_busy2", {31'd0, bif0.busy}, 32'h0);
    chk("c_sig2", {24'd0, bif0.signature}, 32'hEE);
    chk("c_pass", {31'd0, bif0.pass}, 32'h1);
    chk("c_cnt", {16'd0, bif0.vec_cnt}, 32'h2);
    chk("c_stim_uio", {24'd0, bif0.stim_uio}, 32'h0);
    bif0.golden = 8'hEF;
    bif0.start  = 1'b1;
    tick();
    bif0.start = 1'b0;
    chk("c2_done_drop", {31'd0, bif0.done}, 32'h0);
    chk("c2_sig_clr", {24'd0, bif0.signature}, 32'h0);
    tick();
    tick();
    chk("c2_done", {31'd0, bif0.done}, 32'h1);
    chk("c2_pass", {31'd0, bif0.pass}, 32'h0);
    bif0.golden = 8'hEE;
    tick();
    chk("c2_pass_held", {31'd0, bif0.pass}, 32'h0);

    // Latency 3, one vector.
    bif1.start = 1'b1;
    tick();
    bif1.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lat_busy", {31'd0, bif1.busy}, 32'h1);
      bif1.resp_uo = (i == 3) ? 8'h5A : 8'h00;
      tick();
    end
    chk("lat_busy_end", {31'd0, bif1.busy}, 32'h0);
    chk("lat_done", {31'd0, bif1.done}, 32'h1);
    chk("lat_sig", {24'd0, bif1.signature}, 32'h5A);
    chk("lat_cnt", {16'd0, bif1.vec_cnt}, 32'h1);

    // Bidirectional pins contribute only where driven.
    bif1.resp_uo     = 8'h00;
    bif1.resp_uio    = 8'hFF;
    bif1.resp_uio_oe = 8'h0F;
    bif1.start       = 1'b1;
    tick();
    bif1.start = 1'b0;
    repeat (4) tick();
    chk("uio_done", {31'd0, bif1.done}, 32'h1);
`ifdef TT_BIST_UIO_EN
    chk("uio_sig", {24'd0, bif1.signature}, 32'h0F);
`else
    chk("uio_sig", {24'd0, bif1.signature}, 32'h00);
`endif

    // Randomized runs: plain, freeze plus mid-run start, failing golden.
    rand_run(-1, -1, 1'b1);
    rand_run(5, 9, 1'b1);
    rand_run(-1, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
